// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// mem_port_arbiter: shares one single-ported, fixed-latency memory between the
// instruction-fetch and data-memory requesters, one access at a time.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_done_o,
  output logic              if_stall_o,

  input  logic              dm_req_i,
  input  logic              dm_wr_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_done_o,
  output logic              dm_stall_o,

  output logic              mem_en_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,

  output logic              busy_o
);

  localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic            OWN_IF   = 1'b0;
  localparam logic            OWN_DM   = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              grant_dm;

  // On a conflict the requester that did not win last time takes the port.
  assign grant_dm = dm_req_i & (~if_req_i | (last_grant_q == OWN_IF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_IF;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (if_req_i | dm_req_i) begin
          owner_d      = grant_dm ? OWN_DM : OWN_IF;
          last_grant_d = owner_d;
          wr_d         = grant_dm & dm_wr_i;
          addr_d       = grant_dm ? dm_addr_i : if_addr_i;
          wdata_d      = grant_dm ? dm_wdata_i : wdata_q;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Read data is valid exactly now; writes leave both result registers alone.
          if (!wr_q) begin
            if (owner_q == OWN_IF) begin
              if_rdata_d = mem_rdata_i;
            end else begin
              dm_rdata_d = mem_rdata_i;
            end
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_en_o    = (state_q == S_ISSUE);
  assign mem_wr_o    = mem_en_o & wr_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign if_done_o   = (state_q == S_DONE) & (owner_q == OWN_IF);
  assign dm_done_o   = (state_q == S_DONE) & (owner_q == OWN_DM);
  assign if_stall_o  = if_req_i & ~if_done_o;
  assign dm_stall_o  = dm_req_i & ~dm_done_o;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: transaction-level timing model plus a
// reference memory, driven by directed scenarios and random requesters.
`default_nettype none

module tb_mem_port_arbiter;

  localparam int LAT    = 2;
  localparam int OWN_IF = 0;
  localparam int OWN_DM = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        if_req = 1'b0, dm_req = 1'b0, dm_wr = 1'b0;
  logic [15:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_done, if_stall, dm_done, dm_stall, mem_en, mem_wr, busy;

  logic        if1_req = 1'b0;
  logic [15:0] if1_addr = '0;
  logic [15:0] if1_rdata, dm1_rdata, mem1_addr, mem1_wdata, mem1_rdata;
  logic        if1_done, if1_stall, dm1_done, dm1_stall, mem1_en, mem1_wr, busy1;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata),
    .if_done_o(if_done), .if_stall_o(if_stall),
    .dm_req_i(dm_req), .dm_wr_i(dm_wr), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(dm_rdata), .dm_done_o(dm_done), .dm_stall_o(dm_stall),
    .mem_en_o(mem_en), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(1)) u_dut_lat1 (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if1_req), .if_addr_i(if1_addr), .if_rdata_o(if1_rdata),
    .if_done_o(if1_done), .if_stall_o(if1_stall),
    .dm_req_i(1'b0), .dm_wr_i(1'b0), .dm_addr_i(16'h0000), .dm_wdata_i(16'h0000),
    .dm_rdata_o(dm1_rdata), .dm_done_o(dm1_done), .dm_stall_o(dm1_stall),
    .mem_en_o(mem1_en), .mem_wr_o(mem1_wr), .mem_addr_o(mem1_addr),
    .mem_wdata_o(mem1_wdata), .mem_rdata_i(mem1_rdata), .busy_o(busy1)
  );

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hA5A5 : 16'(a * 16'd3 + 16'd7);
  endfunction

  // Memory environment: data appears LAT cycles after the strobe, garbage otherwise.
  logic [15:0] mem [0:65535];
  bit          wrt [0:65535];
  logic [15:0] pa  [LAT];
  logic        pv  [LAT];
  always @(posedge clk) begin
    if (mem_en && mem_wr) begin
      mem[mem_addr] <= mem_wdata;
      wrt[mem_addr] <= 1'b1;
    end
    pa[0] <= mem_addr;
    pv[0] <= mem_en && !mem_wr;
    for (int k = 1; k < LAT; k++) begin
      pa[k] <= pa[k-1];
      pv[k] <= pv[k-1];
    end
  end
  assign mem_rdata = pv[LAT-1] ? (wrt[pa[LAT-1]] ? mem[pa[LAT-1]] : init_val(pa[LAT-1]))
                               : 16'hDEAD;

  logic        p1v = 1'b0;
  logic [15:0] p1a = '0;
  always @(posedge clk) begin
    p1v <= mem1_en && !mem1_wr;
    p1a <= mem1_addr;
  end
  assign mem1_rdata = p1v ? (p1a ^ 16'hC3C3) : 16'hDEAD;

  // Reference model state
  int          cyc = 0, issue_cyc = -100, done_cyc = -100, free_at = 0;
  int          owner = OWN_IF, last_grant = OWN_IF;
  logic        own_wr = 1'b0;
  logic [15:0] own_addr = '0, own_wdata = '0, exp_if_rd = '0, exp_dm_rd = '0;
  logic [15:0] ref_mem [int];
  int          n_checks = 0, n_errors = 0;
  int          obs_cyc [$];
  logic [15:0] obs_addr [$];
  bit          if_keep = 1'b0, dm_keep = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  function automatic logic [15:0] rnd_addr();
    return 16'($urandom_range(0, 15)) << 4;
  endfunction

  task automatic model_reset();
    issue_cyc = -100; done_cyc = -100; free_at = 0;
    owner = OWN_IF; last_grant = OWN_IF;
    exp_if_rd = '0; exp_dm_rd = '0;
  endtask

  task automatic check_outputs();
    bit e_en, e_if_done, e_dm_done;
    if (cyc == done_cyc) begin
      if (own_wr) ref_mem[int'(own_addr)] = own_wdata;
      else if (owner == OWN_IF) exp_if_rd = ref_rd(own_addr);
      else exp_dm_rd = ref_rd(own_addr);
    end
    e_en      = (cyc == issue_cyc);
    e_if_done = (cyc == done_cyc) && (owner == OWN_IF);
    e_dm_done = (cyc == done_cyc) && (owner == OWN_DM);
    if (mem_en) begin
      obs_cyc.push_back(cyc);
      obs_addr.push_back(mem_addr);
    end
    check_val("mem_en", mem_en, e_en);
    if (e_en) begin
      check_val("mem_wr", mem_wr, own_wr);
      check_val("mem_addr", mem_addr, own_addr);
      if (own_wr) check_val("mem_wdata", mem_wdata, own_wdata);
    end
    check_val("if_done", if_done, e_if_done);
    check_val("dm_done", dm_done, e_dm_done);
    check_val("busy", busy, (cyc >= issue_cyc) && (cyc <= done_cyc));
    check_val("if_stall", if_stall, if_req && !e_if_done);
    check_val("dm_stall", dm_stall, dm_req && !e_dm_done);
    check_val("if_rdata", if_rdata, exp_if_rd);
    check_val("dm_rdata", dm_rdata, exp_dm_rd);
  endtask

  // A transaction granted at the end of cycle c occupies the port through c+LAT+2.
  task automatic model_step();
    if (cyc >= free_at && (if_req || dm_req)) begin
      if (if_req && dm_req) owner = 1 - last_grant;
      else owner = dm_req ? OWN_DM : OWN_IF;
      last_grant = owner;
      own_wr     = (owner == OWN_DM) ? dm_wr : 1'b0;
      own_addr   = (owner == OWN_DM) ? dm_addr : if_addr;
      own_wdata  = dm_wdata;
      issue_cyc  = cyc + 1;
      done_cyc   = cyc + LAT + 2;
      free_at    = cyc + LAT + 3;
    end
  endtask

  task automatic run_cycle();
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_directed();
    if ((cyc - 1 == done_cyc) && owner == OWN_IF && !if_keep) if_req = 1'b0;
    if ((cyc - 1 == done_cyc) && owner == OWN_DM && !dm_keep) dm_req = 1'b0;
  endtask

  task automatic drive_random();
    bit if_fin, dm_fin, if_fly, dm_fly;
    if_fin = (cyc - 1 == done_cyc) && owner == OWN_IF;
    dm_fin = (cyc - 1 == done_cyc) && owner == OWN_DM;
    if_fly = owner == OWN_IF && cyc >= issue_cyc && cyc <= done_cyc;
    dm_fly = owner == OWN_DM && cyc >= issue_cyc && cyc <= done_cyc;
    if (if_fin) begin
      if_req  = 1'($urandom_range(0, 1));
      if_addr = rnd_addr();
    end else if (if_fly) begin
      if ($urandom_range(0, 3) == 0) if_addr = rnd_addr();
      if ($urandom_range(0, 15) == 0) if_req = 1'b0;
    end else if (!if_req && $urandom_range(0, 2) == 0) begin
      if_req  = 1'b1;
      if_addr = rnd_addr();
    end
    if (dm_fin || (!dm_fly && !dm_req && $urandom_range(0, 2) == 0)) begin
      dm_req   = dm_fin ? 1'($urandom_range(0, 1)) : 1'b1;
      dm_wr    = 1'($urandom_range(0, 1));
      dm_addr  = rnd_addr();
      dm_wdata = 16'($urandom);
    end else if (dm_fly) begin
      if ($urandom_range(0, 3) == 0) begin
        dm_addr  = rnd_addr();
        dm_wdata = 16'($urandom);
        dm_wr    = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 15) == 0) dm_req = 1'b0;
    end
  endtask

  task automatic run_cycles(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) drive_random();
      else drive_directed();
      run_cycle();
    end
  endtask

  // Called at posedge+1; reset is asserted mid-cycle to exercise the async path.
  task automatic apply_reset();
    if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0; if1_req = 1'b0;
    if_keep = 1'b0; dm_keep = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_mem_en", mem_en, 0);
    check_val("rst_mem_wr", mem_wr, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_if_done", if_done, 0);
    check_val("rst_dm_done", dm_done, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_wdata", mem_wdata, 0);
    check_val("rst_if_rdata", if_rdata, 0);
    check_val("rst_dm_rdata", dm_rdata, 0);
    check_val("rst_busy_lat1", busy1, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    obs_cyc.delete();
    obs_addr.delete();
  endtask

  initial begin
    apply_reset();

    // Fetch read of a preloaded word
    if_req = 1'b1; if_addr = 16'h0010;
    run_cycles(7, 1'b0);
    check_val("t1_if_rdata", if_rdata, 16'hA5A5);
    check_val("t1_issue_addr", obs_addr.size() > 0 ? obs_addr[0] : 16'hFFFF, 16'h0010);

    // Data write then fetch of the same word
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'h1234;
    run_cycles(7, 1'b0);
    dm_wr = 1'b0;
    if_req = 1'b1; if_addr = 16'h0020;
    run_cycles(7, 1'b0);
    check_val("t2_if_rdata", if_rdata, 16'h1234);
    check_val("t2_dm_rdata", dm_rdata, 16'h0000);

    // First conflict after reset goes to DM
    apply_reset();
    if_req = 1'b1; if_addr = 16'h0040;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0030;
    run_cycles(12, 1'b0);
    check_val("t3_n_issue", obs_cyc.size(), 2);
    if (obs_cyc.size() == 2) begin
      check_val("t3_first", obs_addr[0], 16'h0030);
      check_val("t3_second", obs_addr[1], 16'h0040);
      check_val("t3_gap", obs_cyc[1] - obs_cyc[0], 5);
    end
    check_val("t3_dm_rdata", dm_rdata, init_val(16'h0030));

    // Both held: alternation and spacing
    apply_reset();
    if_keep = 1'b1; dm_keep = 1'b1;
    if_req = 1'b1; if_addr = 16'h0050;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0060;
    run_cycles(4 * (LAT + 3), 1'b0);
    check_val("t4_n_issue", obs_cyc.size(), 4);
    for (int i = 0; i < 4 && i < obs_cyc.size(); i++) begin
      check_val("t4_order", obs_addr[i], (i % 2 == 0) ? 16'h0060 : 16'h0050);
      if (i > 0) check_val("t4_gap", obs_cyc[i] - obs_cyc[i-1], LAT + 3);
    end
    if_keep = 1'b0; dm_keep = 1'b0;
    if_req = 1'b0; dm_req = 1'b0;
    run_cycles(LAT + 4, 1'b0);

    // Asynchronous reset in WAIT abandons the access
    apply_reset();
    if_req = 1'b1; if_addr = 16'h0010;
    run_cycles(2, 1'b0);
    check_val("t5_busy_pre", busy, 1);
    apply_reset();
    run_cycles(6, 1'b0);
    check_val("t5_no_issue", obs_cyc.size(), 0);
    if_req = 1'b1; if_addr = 16'h0070;
    run_cycles(7, 1'b0);
    check_val("t5_if_rdata", if_rdata, init_val(16'h0070));

    // LATENCY=1 instance
    apply_reset();
    if1_req = 1'b1; if1_addr = 16'h0010;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) if1_req = 1'b0;
      check_val("lat1_mem_en", mem1_en, k == 1);
      check_val("lat1_if_done", if1_done, k == 3);
      check_val("lat1_dm_done", dm1_done, 0);
      if (k == 3) check_val("lat1_if_rdata", if1_rdata, 16'hC3D3);
      run_cycle();
    end

    // Random traffic
    apply_reset();
    run_cycles(2000, 1'b1);
    if_req = 1'b0; dm_req = 1'b0;
    run_cycles(LAT + 4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the instruction-fetch requester and the data-memory requester. This is the path from single-cycle to multi-cycle memory.
- Latches the granted request, sequences the memory access, returns read data, and raises a per-requester stall until completion.
- Sits between the fetch/memory stages and the memory model. Memory activity presented to the trace bench comes from this block's mem_* outputs.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
LATENCY, 2, cycles from the issue cycle to mem_rdata valid (>=1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch read request; level, held until if_done
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetch read data (registered)
if_done  out  1  one-cycle completion pulse to fetch
if_stall  out  1  if_req & ~if_done
dm_req  in  1  data request; level, held until dm_done
dm_wr  in  1  1 = write, 0 = read
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_rdata  out  DATA_W  data read result (registered)
dm_done  out  1  one-cycle completion pulse to data stage
dm_stall  out  1  dm_req & ~dm_done
mem_en  out  1  memory access strobe, one cycle per transaction
mem_wr  out  1  write enable, valid with mem_en
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  DATA_W  memory read data, valid LATENCY cycles after the mem_en cycle
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE and last_grant to IF.
  - mem_en, mem_wr, if_done, dm_done and busy go to 0.
  - mem_addr, mem_wdata, if_rdata and dm_rdata go to 0.
  - Any in-flight access is abandoned; no done pulse is issued for it.
- FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - If any request is present at the edge, arbitrate and latch owner, addr, wdata and wr, then go to ISSUE. Otherwise stay.
  - Arbitration: a single requester wins alone. If both request, the one not equal to last_grant wins, so the first conflict after reset goes to DM.
  - last_grant updates at every grant.
  - if_req always latches wr=0.
- ISSUE: mem_en=1 for exactly this cycle, with mem_wr/mem_addr/mem_wdata from the latch. Load cnt=LATENCY-1, then go to WAIT.
- WAIT:
  - While cnt!=0, decrement.
  - When cnt==0 (cycle ISSUE+LATENCY): for a read, capture mem_rdata into the owner's rdata register, then go to DONE.
  - Writes leave both rdata registers unchanged.
- DONE: the owner's done is 1 for exactly this cycle, and the other requester's done is 0. Go to IDLE.
- Timing: request seen at end of cycle 0 gives ISSUE in cycle 1 and done in cycle LATENCY+2. Next possible grant is the IDLE cycle LATENCY+3; throughput is 1 access per LATENCY+3 cycles.
- Grants happen only in IDLE. Requests arriving while busy wait and stall.
- Latched fields are immune to input changes after the grant. If req drops mid-transaction, the access still completes and done still pulses.
- Requester contract: on seeing done at an edge, a requester must deassert or present its next request in the following cycle. The arbiter treats a req seen in IDLE as new.
- rdata registers hold their value until the next read completion for that requester.
- mem_en is never high outside ISSUE, and the two done outputs are never high together.

Test Plan:
- LATENCY=2, mem[0x0010]=0xA5A5; if_req addr 0x0010 in cycle 0 -> cycle 1: mem_en=1, mem_wr=0, mem_addr=0x0010; cycle 4: if_done=1, if_rdata=0xA5A5; dm_done=0 throughout.
- dm_req wr=1 addr 0x0020 wdata 0x1234 -> cycle 1: mem_en=1, mem_wr=1, mem_addr=0x0020, mem_wdata=0x1234; cycle 4: dm_done=1; a subsequent fetch of 0x0020 returns 0x1234; dm_rdata unchanged.
- After reset, if_req and dm_req (read 0x0030) both high in cycle 0 -> DM issued cycle 1, dm_done cycle 4; IF issued cycle 6, if_done cycle 9; if_stall=1 in cycles 0-8.
- Both requesters held continuously for 4 transactions -> grant order DM, IF, DM, IF; mem_en pulses spaced 5 cycles apart.
- rst driven low mid-cycle 2 (WAIT) -> mem_en, busy and done drop to 0 immediately without a clock edge; no done pulse for the aborted access; after release a new if_req completes normally with done at cycle +4.
- LATENCY=1 build -> mem_en in cycle 1, mem_rdata captured at end of cycle 2, done in cycle 3.
